// File: rtl/adder_rr_scheduler.sv
// adder_rr_scheduler
// Round-robin front end for a shared, registered W-bit adder. NREQ requesters
// offer operand pairs over valid/ready. At most one pair is granted per cycle
// into the operand stage (S1). The full-width sum moves into the output stage
// (S2) and is presented on a single tagged response channel with backpressure.
module adder_rr_scheduler #(
    parameter int NREQ = 4,
    parameter int W    = 4,
    parameter int IDW  = 2
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [W:0]        rsp_x,
    output logic [IDW-1:0]    rsp_id,
    output logic              busy
);

    // Zero-extend both operands so the carry lands in the MSB instead of wrapping.
    function automatic logic [W:0] add_full(input logic [W-1:0] a, input logic [W-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    logic [IDW-1:0] ptr_q, ptr_d;

    logic           s1_valid_q;
    logic [W-1:0]   s1_a_q;
    logic [W-1:0]   s1_b_q;
    logic [IDW-1:0] s1_id_q;

    logic           rsp_valid_q;
    logic [W:0]     rsp_x_q;
    logic [IDW-1:0] rsp_id_q;

    logic           adv1;
    logic           adv2;
    logic           grant_vld;
    logic [IDW-1:0] grant_id;
    logic [W-1:0]   grant_a;
    logic [W-1:0]   grant_b;

    // S2 can take a new value when empty or being drained; S1 when empty or moving on.
    assign adv2 = !rsp_valid_q || rsp_ready;
    assign adv1 = !s1_valid_q || adv2;

    // Rotating-priority search: indices ptr..NREQ-1 first, then 0..ptr-1.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        grant_a   = '0;
        grant_b   = '0;
        if (resetn && adv1) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!grant_vld && req_valid[i] && (i >= int'(ptr_q))) begin
                    grant_vld = 1'b1;
                    grant_id  = IDW'(i);
                    grant_a   = req_a[i*W +: W];
                    grant_b   = req_b[i*W +: W];
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (!grant_vld && req_valid[i] && (i < int'(ptr_q))) begin
                    grant_vld = 1'b1;
                    grant_id  = IDW'(i);
                    grant_a   = req_a[i*W +: W];
                    grant_b   = req_b[i*W +: W];
                end
            end
        end
    end

    // One-hot ready for the granted requester, all zero otherwise.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = grant_vld && (grant_id == IDW'(i));
        end
    end

    // Pointer moves just past the winner; it holds when nothing is granted.
    always_comb begin
        ptr_d = ptr_q;
        if (grant_vld) begin
            ptr_d = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
        end
    end

    // Operand stage S1 and arbitration pointer.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ptr_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_id_q    <= '0;
        end else begin
            ptr_q <= ptr_d;
            if (adv1) begin
                s1_valid_q <= grant_vld;
                if (grant_vld) begin
                    s1_a_q  <= grant_a;
                    s1_b_q  <= grant_b;
                    s1_id_q <= grant_id;
                end
            end
        end
    end

    // Output stage S2: holds result and tag stable while the consumer stalls.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rsp_valid_q <= 1'b0;
            rsp_x_q     <= '0;
            rsp_id_q    <= '0;
        end else if (adv2) begin
            rsp_valid_q <= s1_valid_q;
            rsp_x_q     <= add_full(s1_a_q, s1_b_q);
            rsp_id_q    <= s1_id_q;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_x     = rsp_x_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = s1_valid_q || rsp_valid_q;

endmodule

// File: tb/tb_adder_rr_scheduler.sv
// Testbench for adder_rr_scheduler (NREQ=4, W=4, IDW=2).
// Granted pairs are pushed to a scoreboard queue with their bench-computed sum
// and index; every consumed response is popped and compared.
module tb_adder_rr_scheduler;

    logic        clock;
    logic        resetn;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [4:0]  rsp_x;
    logic [1:0]  rsp_id;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int npops  = 0;
    logic [6:0] sbq[$];

    adder_rr_scheduler #(.NREQ(4), .W(4), .IDW(2)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_x     (rsp_x),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One clock cycle: at the falling edge record handshakes into the scoreboard
    // and compare consumed responses, then advance to just after the rising edge.
    task automatic tick();
        logic [4:0] s;
        logic [6:0] exp;
        @(negedge clock);
        if (resetn) begin
            for (int i = 0; i < 4; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    s = {1'b0, req_a[i*4 +: 4]} + {1'b0, req_b[i*4 +: 4]};
                    sbq.push_back({i[1:0], s});
                end
            end
            if (rsp_valid && rsp_ready) begin
                checks++;
                npops++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got id=%0d x=%0d, required no response", rsp_id, rsp_x);
                end else begin
                    exp = sbq.pop_front();
                    if ({rsp_id, rsp_x} !== exp) begin
                        errors++;
                        $display("FAIL sb_data: got id=%0d x=%0d, required id=%0d x=%0d",
                                 rsp_id, rsp_x, exp[6:5], exp[4:0]);
                    end
                end
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        req_valid = 4'hF;
        #2;
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b, required 0", rsp_valid); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
        checks++;
        if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b, required 0000", req_ready); end
        @(posedge clock);
        @(posedge clock);
        #1;
        resetn    = 1'b1;
        req_valid = 4'b0000;
        rsp_ready = 1'b1;
        tick();
    endtask

    task automatic test_single();
        req_a[3:0] = 4'd3;
        req_b[3:0] = 4'd5;
        req_valid  = 4'b0001;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready: got %b, required 0001", req_ready); end
        tick();
        req_valid = 4'b0000;
        checks++;
        if ({rsp_valid, busy} !== 2'b01) begin errors++; $display("FAIL single_s1_only: got valid/busy=%b, required 01", {rsp_valid, busy}); end
        tick();
        checks++;
        if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_rsp_valid: got %b, required 1", rsp_valid); end
        checks++;
        if (rsp_x !== 5'd8) begin errors++; $display("FAIL single_rsp_x: got %0d, required 8", rsp_x); end
        checks++;
        if (rsp_id !== 2'd0) begin errors++; $display("FAIL single_rsp_id: got %0d, required 0", rsp_id); end
        tick();
    endtask

    task automatic test_carry();
        req_a[7:4] = 4'd15;
        req_b[7:4] = 4'd15;
        req_valid  = 4'b0010;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin errors++; $display("FAIL carry_ready: got %b, required 0010", req_ready); end
        tick();
        req_valid = 4'b0000;
        tick();
        checks++;
        if (rsp_x !== 5'd30) begin errors++; $display("FAIL carry_rsp_x: got %0d, required 30", rsp_x); end
        checks++;
        if (rsp_id !== 2'd1) begin errors++; $display("FAIL carry_rsp_id: got %0d, required 1", rsp_id); end
        tick();
    endtask

    task automatic test_round_robin();
        int npops0;
        logic [3:0] exp_rdy;
        npops0 = npops;
        // Pointer sits at 2; only req3 valid moves it back to 0.
        req_a[15:12] = 4'd9;
        req_b[15:12] = 4'd4;
        req_valid    = 4'b1000;
        #1;
        checks++;
        if (req_ready !== 4'b1000) begin errors++; $display("FAIL rr_realign_ready: got %b, required 1000", req_ready); end
        tick();
        req_a     = 16'($urandom);
        req_b     = 16'($urandom);
        req_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            #1;
            exp_rdy = 4'b0001 << (k % 4);
            checks++;
            if (req_ready !== exp_rdy) begin errors++; $display("FAIL rr_order_%0d: got %b, required %b", k, req_ready, exp_rdy); end
            tick();
        end
        req_valid = 4'b0000;
        tick();
        tick();
        checks++;
        if (npops - npops0 !== 9) begin errors++; $display("FAIL rr_throughput: got %0d responses, required 9", npops - npops0); end
    endtask

    task automatic test_backpressure();
        int npops0;
        logic [4:0] hold_x;
        logic [1:0] hold_id;
        npops0    = npops;
        req_a     = 16'h5A3C;
        req_b     = 16'hF719;
        req_valid = 4'hF;
        tick();
        req_valid = 4'b0000;
        tick();
        rsp_ready = 1'b0;
        req_valid = 4'hF;
        hold_x    = rsp_x;
        hold_id   = rsp_id;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_absorb_ready: got %b, required 0010", req_ready); end
        tick();
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++;
            if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready_low_%0d: got %b, required 0000", k, req_ready); end
            checks++;
            if ({rsp_valid, rsp_id, rsp_x} !== {1'b1, hold_id, hold_x}) begin
                errors++;
                $display("FAIL bp_hold_%0d: got v=%b id=%0d x=%0d, required v=1 id=%0d x=%0d",
                         k, rsp_valid, rsp_id, rsp_x, hold_id, hold_x);
            end
            tick();
        end
        rsp_ready = 1'b1;
        req_valid = 4'b0000;
        tick();
        tick();
        tick();
        checks++;
        if (npops - npops0 !== 2) begin errors++; $display("FAIL bp_delivered: got %0d responses, required 2", npops - npops0); end
        checks++;
        if (sbq.size() !== 0) begin errors++; $display("FAIL bp_leftover: got %0d pending, required 0", sbq.size()); end
    endtask

    task automatic test_ptr_skip();
        // Grant req0 alone so the pointer lands on 1.
        req_valid = 4'b0001;
        tick();
        req_valid = 4'b0000;
        tick();
        tick();
        req_valid = 4'b0101;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin errors++; $display("FAIL ptr_first: got %b, required 0100", req_ready); end
        tick();
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin errors++; $display("FAIL ptr_second: got %b, required 0001", req_ready); end
        tick();
        req_valid = 4'b0000;
        tick();
        tick();
        checks++;
        if (sbq.size() !== 0) begin errors++; $display("FAIL ptr_leftover: got %0d pending, required 0", sbq.size()); end
    endtask

    task automatic test_reset_mid();
        rsp_ready = 1'b0;
        req_valid = 4'b0110;
        tick();
        tick();
        checks++;
        if ({rsp_valid, busy, req_ready} !== {2'b11, 4'b0000}) begin
            errors++;
            $display("FAIL midrst_full: got valid/busy/ready=%b, required 110000", {rsp_valid, busy, req_ready});
        end
        resetn = 1'b0;
        #1;
        checks++;
        if ({rsp_valid, busy} !== 2'b00) begin errors++; $display("FAIL midrst_clear: got valid/busy=%b, required 00", {rsp_valid, busy}); end
        checks++;
        if (req_ready !== 4'b0000) begin errors++; $display("FAIL midrst_ready: got %b, required 0000", req_ready); end
        sbq.delete();
        @(posedge clock);
        #1;
        resetn    = 1'b1;
        rsp_ready = 1'b1;
        req_valid = 4'b1010;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin errors++; $display("FAIL midrst_first_grant: got %b, required 0010", req_ready); end
        tick();
        req_valid = 4'b0000;
        tick();
        tick();
        tick();
        checks++;
        if (sbq.size() !== 0) begin errors++; $display("FAIL midrst_leftover: got %0d pending, required 0", sbq.size()); end
    endtask

    initial begin
        resetn    = 1'b0;
        req_valid = 4'b0000;
        req_a     = 16'h0000;
        req_b     = 16'h0000;
        rsp_ready = 1'b0;
        test_reset();
        test_single();
        test_carry();
        test_round_robin();
        test_backpressure();
        test_ptr_skip();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
